// File: rtl/star_ram_arbiter_if.sv
// star_ram_arbiter_if: requester-side bus of the star-image pixel RAM arbiter
interface star_ram_arbiter_if #(
    parameter int XSZ   = 3,
    parameter int YSZ   = 3,
    parameter int COLSZ = 3
);
    logic [2:0]         req;
    logic [2:0]         lock;
    logic [2:0]         wr;
    logic [3*XSZ-1:0]   x_in;
    logic [3*YSZ-1:0]   y_in;
    logic [3*COLSZ-1:0] wdata;
    logic [2:0]         gnt;
    logic [2:0]         rvalid;
    logic [COLSZ-1:0]   rdata;
    logic               addr_err;
    modport master (
        output req, lock, wr, x_in, y_in, wdata,
        input  gnt, rvalid, rdata, addr_err
    );
    modport slave (
        input  req, lock, wr, x_in, y_in, wdata,
        output gnt, rvalid, rdata, addr_err
    );
endinterface

// File: rtl/star_ram_arbiter.sv
// star_ram_arbiter: round-robin arbiter with bounded lock sharing the 36x3 pixel RAM
module star_ram_arbiter #(
    parameter int XSZ      = 3,
    parameter int YSZ      = 3,
    parameter int ADDRSZ   = 6,
    parameter int COLSZ    = 3,
    parameter int WIDTH    = 6,
    parameter int HEIGHT   = 6,
    parameter int LOCK_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    star_ram_arbiter_if.slave bus,
    output logic [ADDRSZ-1:0] ram_addr,
    output logic              ram_wren,
    output logic [COLSZ-1:0]  ram_data,
    input  logic [COLSZ-1:0]  ram_q,
    output logic              busy
);
    localparam int CW = $clog2(LOCK_MAX + 1);
    logic [1:0]        ptr, owner, win, s1_id;
    logic [CW-1:0]     cnt;
    logic              win_v, lock_ok, oor;
    logic              s1_v, s1_rd, s1_err, s2_v, s2_err, aerr;
    logic [XSZ-1:0]    xs;
    logic [YSZ-1:0]    ys;
    logic [ADDRSZ-1:0] addr;
    logic [2:0]        rv;
    always_comb begin
        lock_ok = cnt != '0 && int'(cnt) < LOCK_MAX && bus.req[owner] && bus.lock[owner];
        win_v = lock_ok;
        win = lock_ok ? owner : 2'd0;
        for (int k = 0; k < 3; k++)
            if (!win_v && bus.req[2'((int'(ptr) + k) % 3)]) begin
                win_v = 1'b1;
                win = 2'((int'(ptr) + k) % 3);
            end
    end
    assign xs   = bus.x_in[win*XSZ +: XSZ];
    assign ys   = bus.y_in[win*YSZ +: YSZ];
    assign oor  = int'(xs) >= WIDTH || int'(ys) >= HEIGHT;
    assign addr = ADDRSZ'(ys) * ADDRSZ'(WIDTH) + ADDRSZ'(xs);
    assign bus.gnt      = (win_v && !reset) ? 3'b001 << win : 3'b000;
    assign bus.rvalid   = rv;
    assign bus.rdata    = (|rv && !s2_err) ? ram_q : '0;
    assign bus.addr_err = aerr;
    assign busy         = s1_v | s2_v;
    // out-of-range accesses flow through the pipe so rvalid order still matches grant order
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            owner    <= '0;
            cnt      <= '0;
            s1_v     <= 1'b0;
            s1_rd    <= 1'b0;
            s1_id    <= '0;
            s1_err   <= 1'b0;
            aerr     <= 1'b0;
            ram_addr <= '0;
            ram_wren <= 1'b0;
            ram_data <= '0;
            rv       <= '0;
            s2_v     <= 1'b0;
            s2_err   <= 1'b0;
        end else begin
            if (win_v) ptr <= win == 2'd2 ? 2'd0 : win + 2'd1;
            owner    <= win;
            cnt      <= (win_v && bus.lock[win]) ? (lock_ok ? cnt + 1'b1 : CW'(1)) : '0;
            s1_v     <= win_v;
            s1_rd    <= win_v && !bus.wr[win];
            s1_id    <= win;
            s1_err   <= oor;
            aerr     <= win_v && oor;
            ram_wren <= win_v && bus.wr[win] && !oor;
            if (win_v) ram_data <= bus.wdata[win*COLSZ +: COLSZ];
            if (win_v && !oor) ram_addr <= addr;
            rv       <= s1_rd ? 3'b001 << s1_id : 3'b000;
            s2_v     <= s1_v;
            s2_err   <= s1_err;
        end
    end
endmodule

// File: tb/tb_star_ram_arbiter.sv
// tb_star_ram_arbiter: directed and random stimulus against a behavioural arbiter model
module tb_star_ram_arbiter;
    localparam int W = 6, H = 6, LM = 8;
    logic clk = 1'b0, reset = 1'b1;
    always #5 clk = ~clk;
    star_ram_arbiter_if bus();
    logic [5:0] ram_addr;
    logic       ram_wren, busy;
    logic [2:0] ram_data, ram_q;
    star_ram_arbiter dut (
        .clk(clk), .reset(reset), .bus(bus), .ram_addr(ram_addr),
        .ram_wren(ram_wren), .ram_data(ram_data), .ram_q(ram_q), .busy(busy)
    );
    logic [2:0] ram [0:63];
    logic [2:0] ref_mem [0:63];
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_data;
        ram_q <= ram[ram_addr];
    end
    typedef struct {
        bit v; bit rd; bit wr; bit err; int id; logic [2:0] rexp;
    } acc_t;
    acc_t p1, p2;
    int m_ptr, m_owner, m_streak;
    logic [5:0] m_addr;
    logic [2:0] m_data;
    int total = 0, bad = 0;
    logic [2:0] g;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] r, l, w, input logic [8:0] xs, ys, wd);
        bus.req = r; bus.lock = l; bus.wr = w;
        bus.x_in = xs; bus.y_in = ys; bus.wdata = wd;
    endtask

    task automatic model_reset();
        p1 = '{default: '0};
        p2 = '{default: '0};
        m_ptr = 0; m_owner = -1; m_streak = 0;
        m_addr = '0; m_data = '0;
    endtask

    // check one cycle at the falling edge, then advance the model and the clock
    task automatic cyc(output logic [2:0] gout);
        int w;
        bit held;
        logic [2:0] x, y;
        int a;
        @(negedge clk);
        w = -1;
        held = 0;
        if (!reset) begin
            if (m_owner >= 0 && bus.req[m_owner] && bus.lock[m_owner] && m_streak < LM) begin
                w = m_owner;
                held = 1;
            end else
                for (int k = 0; k < 3; k++)
                    if (w < 0 && bus.req[(m_ptr + k) % 3]) w = (m_ptr + k) % 3;
        end
        gout = bus.gnt;
        chk("gnt", bus.gnt, w < 0 ? 0 : 1 << w);
        chk("addr_err", bus.addr_err, p1.v && p1.err);
        chk("ram_wren", ram_wren, p1.v && p1.wr && !p1.err);
        chk("ram_addr", ram_addr, m_addr);
        chk("ram_data", ram_data, m_data);
        chk("rvalid", bus.rvalid, (p2.v && p2.rd) ? 1 << p2.id : 0);
        if (p2.v && p2.rd) chk("rdata", bus.rdata, p2.rexp);
        chk("busy", busy, p1.v || p2.v);
        if (reset) model_reset();
        else begin
            p2 = p1;
            p1 = '{default: '0};
            if (w >= 0) begin
                x = bus.x_in[w*3 +: 3];
                y = bus.y_in[w*3 +: 3];
                a = y * W + x;
                p1.v = 1; p1.id = w; p1.wr = bus.wr[w]; p1.rd = !bus.wr[w];
                p1.err = x >= W || y >= H;
                p1.rexp = p1.err ? 3'd0 : ref_mem[a];
                m_data = bus.wdata[w*3 +: 3];
                if (!p1.err) begin
                    m_addr = 6'(a);
                    if (p1.wr) ref_mem[a] = m_data;
                end
                m_ptr = (w + 1) % 3;
                if (!bus.lock[w]) begin m_owner = -1; m_streak = 0; end
                else if (held) m_streak++;
                else begin m_owner = w; m_streak = 1; end
            end else begin
                m_owner = -1;
                m_streak = 0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    logic [2:0] rr_exp [0:5] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    logic [2:0] lk_exp [0:10] = '{3'b001, 3'b010, 3'b010, 3'b010, 3'b010, 3'b010,
                                  3'b010, 3'b010, 3'b010, 3'b001, 3'b010};

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram[i] = 3'($urandom);
            ref_mem[i] = ram[i];
        end
        ram[8] = 3'd5;
        ref_mem[8] = 3'd5;
        model_reset();
        drive(3'b111, 3'b000, 3'b000, '0, '0, '0);
        repeat (2) @(posedge clk);
        #1;
        cyc(g);
        reset = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(g);
            chk("rr_seq", g, rr_exp[i]);
        end
        drive(3'b000, 3'b000, 3'b000, '0, '0, '0);
        repeat (3) cyc(g);
        drive(3'b001, 3'b000, 3'b000, 9'd2, 9'd1, '0);
        cyc(g);
        drive(3'b000, 3'b000, 3'b000, '0, '0, '0);
        repeat (3) cyc(g);
        drive(3'b100, 3'b000, 3'b100, {3'd5, 6'd0}, {3'd5, 6'd0}, {3'd0, 6'o77});
        cyc(g);
        drive(3'b010, 3'b000, 3'b000, {3'd0, 3'd5, 3'd0}, {3'd0, 3'd5, 3'd0}, '0);
        cyc(g);
        drive(3'b000, 3'b000, 3'b000, '0, '0, '0);
        repeat (3) cyc(g);
        reset = 1'b1;
        cyc(g);
        reset = 1'b0;
        drive(3'b011, 3'b010, 3'b000, 9'o11, 9'o11, '0);
        for (int i = 0; i < 11; i++) begin
            cyc(g);
            chk("lock_seq", g, lk_exp[i]);
        end
        drive(3'b001, 3'b000, 3'b000, 9'd6, 9'd0, '0);
        cyc(g);
        drive(3'b000, 3'b000, 3'b000, '0, '0, '0);
        repeat (3) cyc(g);
        drive(3'b001, 3'b000, 3'b000, 9'd3, 9'd2, '0);
        cyc(g);
        drive(3'b000, 3'b000, 3'b000, '0, '0, '0);
        reset = 1'b1;
        cyc(g);
        reset = 1'b0;
        repeat (3) cyc(g);
        for (int i = 0; i < 600; i++) begin
            drive(3'($urandom), 3'($urandom) | 3'($urandom), 3'($urandom),
                  9'($urandom), 9'($urandom), 9'($urandom));
            reset = $urandom_range(0, 49) == 0;
            cyc(g);
        end
        reset = 1'b0;
        drive(3'b000, 3'b000, 3'b000, '0, '0, '0);
        repeat (3) cyc(g);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
